// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - round-robin arbiter sharing one single-port register file between two requesters
module regfile_arbiter #(
   parameter int WIDTH = 16,
   parameter int ADDR  = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req0_i,
   input  logic             req1_i,
   input  logic             wr0_i,
   input  logic             wr1_i,
   input  logic [ADDR-1:0]  addr0_i,
   input  logic [ADDR-1:0]  addr1_i,
   input  logic [WIDTH-1:0] wdata0_i,
   input  logic [WIDTH-1:0] wdata1_i,
   output logic             gnt0_o,
   output logic             gnt1_o,
   output logic             rvld0_o,
   output logic             rvld1_o,
   output logic [WIDTH-1:0] rdata_o,
   output logic             busy_o,
   output logic [ADDR-1:0]  rf_address_o,
   output logic             rf_wren_o,
   output logic             rf_rden_o,
   output logic [WIDTH-1:0] rf_wrdata_o,
   input  logic [WIDTH-1:0] rf_rddata_i
);

   typedef enum logic [1:0] {IDLE, CMD, RDWAIT} state_e;

   state_e           state_q, state_d;
   logic             last_q, last_d;
   logic             owner_q, owner_d;
   logic             is_wr_q, is_wr_d;
   logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic             rvld0_q, rvld0_d, rvld1_q, rvld1_d;
   logic             busy_q, busy_d;
   logic             rf_wren_q, rf_wren_d, rf_rden_q, rf_rden_d;
   logic [ADDR-1:0]  rf_address_q, rf_address_d;
   logic [WIDTH-1:0] rf_wrdata_q, rf_wrdata_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             winner;
   logic             win_wr;

   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      owner_d      = owner_q;
      is_wr_d      = is_wr_q;
      gnt0_d       = 1'b0;
      gnt1_d       = 1'b0;
      rvld0_d      = 1'b0;
      rvld1_d      = 1'b0;
      rf_wren_d    = 1'b0;
      rf_rden_d    = 1'b0;
      rf_address_d = rf_address_q;
      rf_wrdata_d  = rf_wrdata_q;
      rdata_d      = rdata_q;
      // On contention the requester that did not win last time gets the slot.
      winner       = (req0_i && req1_i) ? ~last_q : req1_i;
      win_wr       = winner ? wr1_i : wr0_i;

      case (state_q)
         IDLE: begin
            if (req0_i || req1_i) begin
               state_d      = CMD;
               last_d       = winner;
               owner_d      = winner;
               is_wr_d      = win_wr;
               gnt0_d       = ~winner;
               gnt1_d       = winner;
               rf_wren_d    = win_wr;
               rf_rden_d    = ~win_wr;
               rf_address_d = winner ? addr1_i : addr0_i;
               rf_wrdata_d  = winner ? wdata1_i : wdata0_i;
            end
         end
         CMD: begin
            state_d = is_wr_q ? IDLE : RDWAIT;
         end
         RDWAIT: begin
            rdata_d = rf_rddata_i;
            rvld0_d = ~owner_q;
            rvld1_d = owner_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         last_q       <= 1'b1;
         owner_q      <= 1'b0;
         is_wr_q      <= 1'b0;
         gnt0_q       <= 1'b0;
         gnt1_q       <= 1'b0;
         rvld0_q      <= 1'b0;
         rvld1_q      <= 1'b0;
         busy_q       <= 1'b0;
         rf_wren_q    <= 1'b0;
         rf_rden_q    <= 1'b0;
         rf_address_q <= '0;
         rf_wrdata_q  <= '0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         owner_q      <= owner_d;
         is_wr_q      <= is_wr_d;
         gnt0_q       <= gnt0_d;
         gnt1_q       <= gnt1_d;
         rvld0_q      <= rvld0_d;
         rvld1_q      <= rvld1_d;
         busy_q       <= busy_d;
         rf_wren_q    <= rf_wren_d;
         rf_rden_q    <= rf_rden_d;
         rf_address_q <= rf_address_d;
         rf_wrdata_q  <= rf_wrdata_d;
         rdata_q      <= rdata_d;
      end
   end

   assign gnt0_o       = gnt0_q;
   assign gnt1_o       = gnt1_q;
   assign rvld0_o      = rvld0_q;
   assign rvld1_o      = rvld1_q;
   assign rdata_o      = rdata_q;
   assign busy_o       = busy_q;
   assign rf_address_o = rf_address_q;
   assign rf_wren_o    = rf_wren_q;
   assign rf_rden_o    = rf_rden_q;
   assign rf_wrdata_o  = rf_wrdata_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - directed self-checking bench for regfile_arbiter with a behavioural register file
module tb_regfile_arbiter;

   logic        clk;
   logic        rst;
   logic        req0, req1, wr0, wr1;
   logic [2:0]  addr0, addr1;
   logic [15:0] wdata0, wdata1;
   logic        gnt0, gnt1, rvld0, rvld1, busy;
   logic [15:0] rdata;
   logic [2:0]  rf_address;
   logic        rf_wren, rf_rden;
   logic [15:0] rf_wrdata;
   logic [15:0] rf_rddata;
   logic [15:0] mem [8];

   int n_cmp = 0;
   int n_err = 0;

   regfile_arbiter #(.WIDTH(16), .ADDR(3)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req0_i       (req0),
      .req1_i       (req1),
      .wr0_i        (wr0),
      .wr1_i        (wr1),
      .addr0_i      (addr0),
      .addr1_i      (addr1),
      .wdata0_i     (wdata0),
      .wdata1_i     (wdata1),
      .gnt0_o       (gnt0),
      .gnt1_o       (gnt1),
      .rvld0_o      (rvld0),
      .rvld1_o      (rvld1),
      .rdata_o      (rdata),
      .busy_o       (busy),
      .rf_address_o (rf_address),
      .rf_wren_o    (rf_wren),
      .rf_rden_o    (rf_rden),
      .rf_wrdata_o  (rf_wrdata),
      .rf_rddata_i  (rf_rddata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port register file with registered read.
   initial begin
      for (int i = 0; i < 8; i++) mem[i] = '0;
      rf_rddata = '0;
   end
   always @(posedge clk) begin
      if (rf_wren) mem[rf_address] <= rf_wrdata;
      if (rf_rden) rf_rddata <= mem[rf_address];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic do_write(input logic who, input logic [2:0] a, input logic [15:0] d);
      if (!who) begin req0 = 1; wr0 = 1; addr0 = a; wdata0 = d; end
      else      begin req1 = 1; wr1 = 1; addr1 = a; wdata1 = d; end
      @(posedge clk); #1;
      check("wr_gnt0", gnt0, !who);
      check("wr_gnt1", gnt1, who);
      check("wr_wren", rf_wren, 1);
      check("wr_rden", rf_rden, 0);
      check("wr_addr", rf_address, a);
      check("wr_data", rf_wrdata, d);
      req0 = 0; req1 = 0;
      @(posedge clk); #1;
      check("wr_done_busy", busy, 0);
   endtask

   task automatic do_read(input logic who, input logic [2:0] a, input logic [15:0] expd);
      if (!who) begin req0 = 1; wr0 = 0; addr0 = a; end
      else      begin req1 = 1; wr1 = 0; addr1 = a; end
      @(posedge clk); #1;
      check("rd_gnt0", gnt0, !who);
      check("rd_gnt1", gnt1, who);
      check("rd_rden", rf_rden, 1);
      check("rd_wren", rf_wren, 0);
      check("rd_addr", rf_address, a);
      check("rd_busy_cmd", busy, 1);
      req0 = 0; req1 = 0;
      @(posedge clk); #1;
      check("rd_wait_rden", rf_rden, 0);
      check("rd_wait_busy", busy, 1);
      check("rd_wait_rvld", {rvld0, rvld1}, 2'b00);
      @(posedge clk); #1;
      check("rd_rvld0", rvld0, !who);
      check("rd_rvld1", rvld1, who);
      check("rd_rdata", rdata, expd);
      check("rd_idle_busy", busy, 0);
   endtask

   initial begin
      rst = 1;
      req0 = 1'($urandom); req1 = 1'($urandom); wr0 = 1'($urandom); wr1 = 1'($urandom);
      addr0 = 3'($urandom); addr1 = 3'($urandom);
      wdata0 = 16'($urandom); wdata1 = 16'($urandom);
      #2;
      @(posedge clk); #1;
      check("rst_gnt", {gnt0, gnt1}, 2'b00);
      check("rst_rvld", {rvld0, rvld1}, 2'b00);
      check("rst_rdata", rdata, 0);
      check("rst_busy", busy, 0);
      check("rst_rf_addr", rf_address, 0);
      check("rst_rf_en", {rf_wren, rf_rden}, 2'b00);
      check("rst_rf_wrdata", rf_wrdata, 0);

      req0 = 0; req1 = 0;
      rst = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("idle_busy", busy, 0);
         check("idle_en", {rf_wren, rf_rden}, 2'b00);
      end

      do_write(0, 3'd3, 16'hA5A5);
      do_read(0, 3'd3, 16'hA5A5);

      // Fresh reset so the contention order starts from Last=1.
      @(posedge clk); #1;
      rst = 1; #2; rst = 0;
      req0 = 1; wr0 = 1; addr0 = 3'd1; wdata0 = 16'h0101;
      req1 = 1; wr1 = 1; addr1 = 3'd4; wdata1 = 16'h0404;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         check("cont_gnt0", gnt0, (k % 2) == 0);
         check("cont_gnt1", gnt1, (k % 2) == 1);
         check("cont_addr", rf_address, ((k % 2) == 0) ? 3'd1 : 3'd4);
         @(posedge clk); #1;
         check("cont_gap", {gnt0, gnt1}, 2'b00);
      end
      req0 = 0; req1 = 0;
      do_read(1, 3'd4, 16'h0404);

      do_write(1, 3'd5, 16'h1234);
      req1 = 1; wr1 = 0; addr1 = 3'd5;
      @(posedge clk); #1;
      check("ovl_gnt1", gnt1, 1);
      req1 = 0;
      @(posedge clk); #1;
      req0 = 1; wr0 = 1; addr0 = 3'd6; wdata0 = 16'hBEEF;
      check("ovl_rdwait_gnt0", gnt0, 0);
      @(posedge clk); #1;
      check("ovl_idle_gnt0", gnt0, 0);
      check("ovl_rvld1", rvld1, 1);
      check("ovl_rvld0", rvld0, 0);
      check("ovl_rdata", rdata, 16'h1234);
      @(posedge clk); #1;
      check("ovl_gnt0", gnt0, 1);
      check("ovl_wren", rf_wren, 1);
      check("ovl_wdata", rf_wrdata, 16'hBEEF);
      req0 = 0;
      @(posedge clk); #1;

      req0 = 1; wr0 = 1; addr0 = 3'd2; wdata0 = 16'hFFFF;
      @(posedge clk); #1;
      check("rstw_wren_pre", rf_wren, 1);
      rst = 1;
      #1;
      check("rstw_wren", rf_wren, 0);
      check("rstw_gnt0", gnt0, 0);
      check("rstw_busy", busy, 0);
      req0 = 0;
      @(posedge clk); #1;
      rst = 0;
      do_read(0, 3'd2, 16'h0000);

      for (int a = 0; a < 8; a++) do_write(1, 3'(a), 16'h1000 + 16'(a));
      for (int a = 0; a < 8; a++) do_read(1, 3'(a), 16'h1000 + 16'(a));
      do_read(1, 3'd0, 16'h1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Round-robin arbiter that shares one single-port register file (8 x 16, registered read, one operation per cycle, write and read mutually exclusive) between two requesters. It accepts read/write requests, issues exactly one register-file command per transaction, captures the read result and returns it to the owning requester with a valid pulse. It sits between the two client blocks and the register file, driving all of the register file's address, enable and write-data inputs.

## Interface
- WIDTH, 16, data width of register file and requesters
- ADDR, 3, address width (register file depth = 2^ADDR)

- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- Req0 / Req1  in  1  request from requester 0 / 1
- Wr0 / Wr1  in  1  1 = write, 0 = read; qualified by Req
- Addr0 / Addr1  in  ADDR  register address
- WData0 / WData1  in  WIDTH  write data
- Gnt0 / Gnt1  out  1  one-cycle pulse: request accepted and command issued this cycle
- RVld0 / RVld1  out  1  one-cycle pulse: RData holds this requester's read result
- RData  out  WIDTH  read result, shared by both requesters
- Busy  out  1  high when state is not IDLE
- RF_Address  out  ADDR  to register file Address
- RF_WrEn  out  1  to register file WrEn
- RF_RdEn  out  1  to register file RdEn
- RF_WrData  out  WIDTH  to register file WrData
- RF_RdData  in  WIDTH  from register file RdData

## Operation
- FSM states:
  - IDLE: samples Req0/Req1. If any is high, latch the winner's Wr, Addr and WData and go to CMD; otherwise stay in IDLE.
  - CMD: RF_WrEn or RF_RdEn high for this single cycle, with RF_Address and RF_WrData from the latched request. Winner's Gnt is high. Write goes to IDLE; read goes to RDWAIT.
  - RDWAIT: RF_RdData is valid; register it into RData at the end of the cycle. Go to IDLE.
- RVld of the read owner pulses in the cycle after RDWAIT. This cycle is an IDLE cycle, so arbitration continues concurrently.
- Arbitration:
  - Last register holds the index of the last granted requester; reset value 1.
  - If only one requester is high, it wins.
  - If both are high, the requester != Last wins, giving strict alternation.
  - Last updates on entry to CMD.
- Requests are sampled only in IDLE and ignored in CMD/RDWAIT.
- The requester must hold Req/Wr/Addr/WData stable until its Gnt.
- Req still high in the IDLE cycle after Gnt is a new request. For a single transaction, the requester drops Req at the edge ending the Gnt cycle.
- RF_WrEn and RF_RdEn are never both high. Both are low outside CMD.
- RF outputs, Gnt, RVld, RData and Busy are all registered; none is combinational from inputs.
- RData holds its last value until the next read completes. RVld0 and RVld1 are never high together.
- Gnt0 and Gnt1 are mutually exclusive.
- No address range checking is needed: ADDR bits cover the full depth.

## Timing
- Reset values: Gnt0=Gnt1=0, RVld0=RVld1=0, RData=0, Busy=0, RF_Address=0, RF_WrEn=0, RF_RdEn=0, RF_WrData=0, state=IDLE, Last=1.
- When a request is sampled at the edge ending IDLE cycle t:
  - Gnt and the RF command occur in cycle t+1.
  - A write lands in the register file at the edge ending t+1.
  - A read returns RVld/RData in cycle t+3.
- Throughput: write every 2 cycles, read every 3 cycles. Busy is high in CMD and RDWAIT.
- RST asserted in any state, including mid-CMD: all outputs go to reset values immediately (asynchronous). A pending write is not performed, the in-flight read is discarded with no RVld, and Last returns to 1.
- After RST is released, the first IDLE cycle samples requests normally.

## Test plan
- Reset: RST=1 with random inputs -> all outputs 0. Release with no Req -> Busy=0 and no RF enables for 10 cycles.
- Write/read by requester 0:
  - Req0=1, Wr0=1, Addr0=3, WData0=16'hA5A5 sampled at t -> cycle t+1: Gnt0=1, RF_WrEn=1, RF_Address=3, RF_WrData=16'hA5A5.
  - Then a read of Addr0=3 -> RF_RdEn=1 in its CMD cycle; RVld0=1 and RData=16'hA5A5 two cycles later; RVld1 stays 0.
- Contention: Req0 and Req1 held high continuously, both writing -> grant order 0,1,0,1,… with one grant every 2 cycles and no starvation.
- Overlap: requester 1 reads address 5 (preloaded 16'h1234) while Req0 write rises during RDWAIT:
  - Gnt0 is not issued before IDLE.
  - RVld1=1 with RData=16'h1234 in the same cycle that the write is sampled.
  - Gnt0 follows one cycle later.
- Reset mid-write: RST pulsed during the CMD cycle of a write of 16'hFFFF to address 2 -> RF_WrEn drops immediately and Gnt is cleared. A later read of address 2 returns 0.
- Sweep: requester 1 writes addresses 0..7 with values 16'h1000+addr, then reads all 8 back -> each RVld1 carries the matching value. Address 7 is followed by 0 with no aliasing.
